// File: rtl/fixed_point_sign_restore.sv
// fixed_point_sign_restore
// Restores the sign stripped by an upstream absolute-value stage. Signs are
// queued in an in-order FIFO as operands are made unsigned; each returning
// magnitude pops the oldest sign and leaves as a registered two's-complement
// value one cycle later.
//
// Optional build macro: FIXED_POINT_SIGN_RESTORE_SAT_EN
//   defined   - magnitudes with the MSB set are clamped to the largest positive
//               value before the sign is applied (0x80 -> 0x7F / 0x81).
//   undefined - magnitudes are used raw and wrap (0x80 -> 0x80 for either sign).
module fixed_point_sign_restore #(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 3,
    parameter int DEPTH     = 4
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       SIGN_IN,
    input  logic                       SIGN_VALID_IN,
    input  logic [WIDTH-1:0]           MAG_IN,
    input  logic                       MAG_VALID_IN,
    output logic signed [WIDTH-1:0]    VALUE_OUT,
    output logic                       VALID_OUT,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Negation is format-preserving, so FRAC_BITS only has to describe a
    // legal format; it never enters the arithmetic.
    if (WIDTH < 2 || FRAC_BITS < 0 || FRAC_BITS > WIDTH ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("fixed_point_sign_restore: illegal WIDTH/FRAC_BITS/DEPTH");
    end

    // Clamp out-of-range magnitudes (MSB set) when saturation is built in.
    function automatic logic [WIDTH-1:0] sat_mag(input logic [WIDTH-1:0] mag);
`ifdef FIXED_POINT_SIGN_RESTORE_SAT_EN
        if (mag[WIDTH-1]) begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
        return mag;
`else
        return mag;
`endif
    endfunction

    // Two's-complement negate when the stored sign is negative; 0 stays 0.
    function automatic logic signed [WIDTH-1:0] apply_sign(input logic neg,
                                                           input logic [WIDTH-1:0] mag);
        logic signed [WIDTH-1:0] mag_s;
        mag_s = $signed(mag);
        return neg ? -mag_s : mag_s;
    endfunction

    logic [DEPTH-1:0]        sign_mem_p0;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    ovf_flag;
    logic                    unf_flag;
    logic signed [WIDTH-1:0] value_p1;
    logic                    vld_p1;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    do_pop;
    logic                    do_push;
    logic                    push_drop;
    logic                    pop_fail;
    logic                    sign_rd;
    logic signed [WIDTH-1:0] result_p0;

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    // alongside a pop. No bypass: an empty FIFO never pops, even with a push.
    assign do_pop    = MAG_VALID_IN && !fifo_empty;
    assign do_push   = SIGN_VALID_IN && (!fifo_full || do_pop);
    assign push_drop = SIGN_VALID_IN && fifo_full && !do_pop;
    assign pop_fail  = MAG_VALID_IN && fifo_empty;

    // Stage p0: read the oldest sign before any same-cycle write lands.
    assign sign_rd   = sign_mem_p0[rd_ptr];
    assign result_p0 = apply_sign(sign_rd, sat_mag(MAG_IN));

    // Sign storage is pure data; pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            sign_mem_p0[wr_ptr] <= SIGN_IN;
        end
    end

    // FIFO pointers, occupancy and sticky error flags.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            if (push_drop) begin
                ovf_flag <= 1'b1;
            end
            if (pop_fail) begin
                unf_flag <= 1'b1;
            end
        end
    end

    // Stage p1: registered result and its strobe; the value holds between pops.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            value_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= do_pop;
            if (do_pop) begin
                value_p1 <= result_p0;
            end
        end
    end

    assign VALUE_OUT = value_p1;
    assign VALID_OUT = vld_p1;
    assign FULL      = fifo_full;
    assign EMPTY     = fifo_empty;
    assign COUNT     = count;
    assign OVERFLOW  = ovf_flag;
    assign UNDERFLOW = unf_flag;

endmodule

// File: tb/tb_fixed_point_sign_restore.sv
// Testbench for fixed_point_sign_restore (WIDTH=8, FRAC_BITS=3, DEPTH=4).
// Results are checked through an expected-value queue drained by a monitor;
// FIFO status is checked directly after each edge.
module tb_fixed_point_sign_restore;

    localparam int WIDTH     = 8;
    localparam int FRAC_BITS = 3;
    localparam int DEPTH     = 4;

    logic              CLK = 1'b0;
    logic              RSTN = 1'b0;
    logic              SIGN_IN = 1'b0;
    logic              SIGN_VALID_IN = 1'b0;
    logic [WIDTH-1:0]  MAG_IN = '0;
    logic              MAG_VALID_IN = 1'b0;
    logic signed [WIDTH-1:0] VALUE_OUT;
    logic              VALID_OUT;
    logic              FULL;
    logic              EMPTY;
    logic [2:0]        COUNT;
    logic              OVERFLOW;
    logic              UNDERFLOW;

    fixed_point_sign_restore #(
        .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RSTN(RSTN),
        .SIGN_IN(SIGN_IN), .SIGN_VALID_IN(SIGN_VALID_IN),
        .MAG_IN(MAG_IN), .MAG_VALID_IN(MAG_VALID_IN),
        .VALUE_OUT(VALUE_OUT), .VALID_OUT(VALID_OUT),
        .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       sign;
        logic [7:0] mag;
        logic [7:0] exp;
    } vec_t;

`ifdef FIXED_POINT_SIGN_RESTORE_SAT_EN
    localparam logic [7:0] E80_NEG = 8'h81;
    localparam logic [7:0] E80_POS = 8'h7F;
    localparam logic [7:0] EFF_NEG = 8'h81;
    localparam logic [7:0] EFF_POS = 8'h7F;
`else
    localparam logic [7:0] E80_NEG = 8'h80;
    localparam logic [7:0] E80_POS = 8'h80;
    localparam logic [7:0] EFF_NEG = 8'h01;
    localparam logic [7:0] EFF_POS = 8'hFF;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Every VALID_OUT must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RSTN && VALID_OUT) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: got value %0h, required no VALID_OUT", VALUE_OUT);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if ($unsigned(VALUE_OUT) !== e) begin
                    n_bad++;
                    $display("FAIL value_out: got %0h, required %0h", VALUE_OUT, e);
                end
            end
        end
    end

    // One clock: drive, capture on the rising edge, release, leave at edge+1.
    task automatic cyc(input logic sv, input logic s, input logic mv, input logic [7:0] m);
        SIGN_VALID_IN = sv;
        SIGN_IN       = s;
        MAG_VALID_IN  = mv;
        MAG_IN        = m;
        @(posedge CLK);
        #1;
        SIGN_VALID_IN = 1'b0;
        MAG_VALID_IN  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_value"},     32'($unsigned(VALUE_OUT)), 0);
        chk({tag, "_valid"},     32'(VALID_OUT), 0);
        chk({tag, "_full"},      32'(FULL), 0);
        chk({tag, "_empty"},     32'(EMPTY), 1);
        chk({tag, "_count"},     32'(COUNT), 0);
        chk({tag, "_overflow"},  32'(OVERFLOW), 0);
        chk({tag, "_underflow"}, 32'(UNDERFLOW), 0);
    endtask

    task automatic do_reset(input string tag);
        RSTN = 1'b0;
        #1;
        check_reset_vals(tag);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
    endtask

    task automatic drain_check(input string tag);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        #1;
        chk({tag, "_outstanding"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        logic [7:0] last;
        logic [3:0] signs;
        logic [7:0] m;

        vecs[0]  = '{1'b1, 8'h0C, 8'hF4};
        vecs[1]  = '{1'b0, 8'h28, 8'h28};
        vecs[2]  = '{1'b1, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 8'h7F, 8'h81};
        vecs[5]  = '{1'b0, 8'h7F, 8'h7F};
        vecs[6]  = '{1'b1, 8'h01, 8'hFF};
        vecs[7]  = '{1'b1, 8'h80, E80_NEG};
        vecs[8]  = '{1'b0, 8'h80, E80_POS};
        vecs[9]  = '{1'b1, 8'hFF, EFF_NEG};
        vecs[10] = '{1'b0, 8'hFF, EFF_POS};

        #2;
        check_reset_vals("por");
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;

        // Single push then pop per vector.
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, vecs[i].sign, 1'b0, 8'h00);
            chk("vec_count_after_push", 32'(COUNT), 1);
            exp_q.push_back(vecs[i].exp);
            cyc(1'b0, 1'b0, 1'b1, vecs[i].mag);
            chk("vec_empty_after_pop", 32'(EMPTY), 1);
        end
        last = vecs[10].exp;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        chk("hold_valid_low", 32'(VALID_OUT), 0);
        chk("hold_value", 32'($unsigned(VALUE_OUT)), 32'(last));
        drain_check("vectors");

        // Fill, overflow, drain in order.
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        chk("fill_full", 32'(FULL), 1);
        chk("fill_count", 32'(COUNT), 4);
        chk("fill_no_overflow", 32'(OVERFLOW), 0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("ovf_flag", 32'(OVERFLOW), 1);
        chk("ovf_count", 32'(COUNT), 4);
        exp_q.push_back(8'hF8);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'hF8);
        exp_q.push_back(8'hF8);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'h08);
        chk("drain_empty", 32'(EMPTY), 1);
        chk("ovf_sticky", 32'(OVERFLOW), 1);
        drain_check("overflow");

        // Pop on empty with simultaneous push: no bypass.
        do_reset("rst1");
        cyc(1'b1, 1'b1, 1'b1, 8'h33);
        chk("unf_flag", 32'(UNDERFLOW), 1);
        chk("unf_count", 32'(COUNT), 1);
        exp_q.push_back(8'hF0);
        cyc(1'b0, 1'b0, 1'b1, 8'h10);
        chk("unf_then_empty", 32'(EMPTY), 1);
        drain_check("underflow");

        // Push and pop together while full, then wrap over three passes.
        do_reset("rst2");
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        exp_q.push_back(8'hF8);
        cyc(1'b1, 1'b0, 1'b1, 8'h08);
        chk("full_pp_count", 32'(COUNT), 4);
        chk("full_pp_overflow", 32'(OVERFLOW), 0);
        chk("full_pp_full", 32'(FULL), 1);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'hF8);
        exp_q.push_back(8'hF8);
        exp_q.push_back(8'h08);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'h08);
        chk("full_pp_empty", 32'(EMPTY), 1);
        for (int p = 0; p < 3; p++) begin
            signs = 4'($urandom_range(0, 15));
            if (p == 0) signs = 4'b1010;
            for (int i = 0; i < 4; i++) cyc(1'b1, signs[i], 1'b0, 8'h00);
            chk("pass_full", 32'(FULL), 1);
            for (int i = 0; i < 4; i++) begin
                m = 8'($urandom_range(0, 127));
                exp_q.push_back(signs[i] ? 8'(8'h00 - m) : m);
                cyc(1'b0, 1'b0, 1'b1, m);
            end
            chk("pass_empty", 32'(EMPTY), 1);
        end
        chk("wrap_no_flags", 32'({OVERFLOW, UNDERFLOW}), 0);
        drain_check("wrap");

        // Asynchronous reset with a result in flight.
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("mid_count", 32'(COUNT), 3);
        cyc(1'b1, 1'b1, 1'b1, 8'h05);
        RSTN = 1'b0;
        #1;
        check_reset_vals("async");
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 8'h10);
        chk("post_rst_underflow", 32'(UNDERFLOW), 1);
        chk("post_rst_count", 32'(COUNT), 0);
        drain_check("reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fixed_point_sign_restore.md
# fixed_point_sign_restore

Re-applies a stored sign to a fixed-point magnitude, the inverse of the absolute-value stage. The sign of each operand is pushed into a small in-order FIFO when its absolute value is taken. When the processed unsigned magnitude returns from the downstream datapath, the oldest sign is popped and the signed two's-complement result is produced. The block sits at the output of any magnitude-only datapath section and closes the sign-strip / sign-restore pair.

## Interface
- WIDTH, 8, data width in bits (≥2)
- FRAC_BITS, 3, fractional bits; format only; negation is format-preserving, so arithmetic is unaffected
- DEPTH, 4, sign FIFO depth; power of two, ≥2

- CLK  in  1  clock; all logic on the rising edge
- RSTN  in  1  reset; one clock; reset is asynchronous and active-low
- SIGN_IN  in  1  sign to store; 1 = negative
- SIGN_VALID_IN  in  1  push SIGN_IN into the FIFO
- MAG_IN  in  WIDTH  magnitude, unsigned interpretation
- MAG_VALID_IN  in  1  magnitude valid; pops one sign
- VALUE_OUT  out  WIDTH  signed result, registered
- VALID_OUT  out  1  single-cycle strobe qualifying VALUE_OUT
- FULL  out  1  FIFO holds DEPTH signs
- EMPTY  out  1  FIFO holds no signs
- COUNT  out  $clog2(DEPTH)+1  number of stored signs
- OVERFLOW  out  1  sticky; a push was dropped
- UNDERFLOW  out  1  sticky; a magnitude arrived with no sign stored

## Operation
- Sign FIFO: circular buffer of DEPTH bits. Read and write pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0. COUNT is tracked explicitly. FULL = (COUNT==DEPTH). EMPTY = (COUNT==0).
- Push: SIGN_VALID_IN && (!FULL || pop this cycle) → write at the write pointer, advance it.
- Pop: MAG_VALID_IN && !EMPTY → read the sign at the read pointer, advance it, register the result.
- Result: sign 0 → VALUE_OUT = MAG_IN. Sign 1 → VALUE_OUT = (~MAG_IN + 1) mod 2^WIDTH. Sign 1 with MAG_IN 0 gives 0; no negative zero.
- Magnitude MSB set (out of positive range, e.g. an ABS of the most-negative value): handled per Configuration.
- Simultaneous push and pop with FIFO non-empty: both happen and COUNT is unchanged.
- Simultaneous push and pop with FIFO full: both happen and no overflow is flagged.
- Simultaneous push and pop with FIFO empty: no bypass. The pop fails (UNDERFLOW, magnitude dropped, no VALID_OUT) and the push is stored, so COUNT becomes 1.
- Overflow: push while FULL without a pop → sign dropped, FIFO unchanged, OVERFLOW←1.
- Underflow: MAG_VALID_IN while EMPTY → magnitude dropped, VALID_OUT stays 0, UNDERFLOW←1.
- OVERFLOW and UNDERFLOW clear only on reset.

## Timing
- Reset values: VALUE_OUT=0, VALID_OUT=0, FULL=0, EMPTY=1, COUNT=0, OVERFLOW=0, UNDERFLOW=0, pointers=0.
- Latency: VALID_OUT and VALUE_OUT update exactly 1 cycle after the MAG_VALID_IN edge. One result per cycle at full throughput.
- VALUE_OUT holds its last value while VALID_OUT=0.
- FULL, EMPTY and COUNT reflect state after the edge. A pushed sign is poppable from the next cycle.
- Flags assert on the edge after the offending request.
- Reset mid-operation: all outputs go to reset values immediately (asynchronously) and stored signs are discarded. A result in flight is lost and does not emit VALID_OUT.
- No backpressure: the consumer must accept every VALID_OUT.

## Configuration
- FIXED_POINT_SIGN_RESTORE_SAT_EN defined: MAG_IN with MSB set is clamped to the maximum positive value {0,{WIDTH-1{1}}} before the sign is applied. Sign 0 gives 0x7F…F; sign 1 gives 0x80…01.
- Not defined: no clamping. MAG_IN is used raw; two's-complement wrap applies and 0x80…0 maps to 0x80…0 for either sign.

## Test plan
All scenarios use WIDTH=8, FRAC_BITS=3, DEPTH=4.
- Push sign 1, then MAG_IN=0x0C (1.5) → next cycle VALID_OUT=1, VALUE_OUT=0xF4 (-1.5). Push sign 0, MAG_IN=0x28 → 0x28.
- Push signs 1,0,1,1 → FULL=1, COUNT=4. A 5th push → OVERFLOW=1, COUNT=4. Then MAG_IN=0x08 ×4 → 0xF8, 0x08, 0xF8, 0xF8, and EMPTY=1.
- MAG_VALID_IN with EMPTY=1 and a simultaneous push of sign 1 → no VALID_OUT, UNDERFLOW=1, COUNT=1. A next MAG_IN=0x10 → 0xF0.
- FIFO full, push sign 0 and pop the same cycle → COUNT stays 4, OVERFLOW=0. Pointers wrap correctly over 3 full fill/drain passes with order preserved.
- MAG_IN=0x80: with SAT_EN, sign 1 → 0x81 and sign 0 → 0x7F. Without SAT_EN, both → 0x80. Sign 1 with MAG_IN=0x00 → 0x00.
- Assert RSTN low mid-stream with COUNT=3 → all outputs at reset values within the same cycle, flags cleared, and a subsequent pop underflows.
